// File: rtl/demux_channel_sequencer.sv
// rtl/demux_channel_sequencer.sv - scan sequencer driving the 3-to-8 demux select
module demux_channel_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       en,
    input  logic       cont,
    input  logic [7:0] mask,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic       busy,
    output logic       done
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    mask_q, mask_n;
    logic          cont_q, cont_n;
    logic [2:0]    sel_n;
    logic          sel_valid_n, busy_n, done_n;
    logic          has_next;
    logic [2:0]    next_sel;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    // Next higher enabled channel above the current select; descending scan keeps the lowest hit
    always_comb begin
        has_next = 1'b0;
        next_sel = sel;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (3'(i) > sel)) begin
                has_next = 1'b1;
                next_sel = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mask_q    <= 8'd0;
            cont_q    <= 1'b0;
            sel       <= 3'd0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mask_q    <= mask_n;
            cont_q    <= cont_n;
            sel       <= sel_n;
            sel_valid <= sel_valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        mask_n      = mask_q;
        cont_n      = cont_q;
        sel_n       = sel;
        sel_valid_n = sel_valid;
        busy_n      = busy;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    mask_n = mask;
                    cont_n = cont;
                    cnt_n  = '0;
                    if (mask != 8'd0) begin
                        state_n     = SCAN;
                        sel_n       = lowest_bit(mask);
                        sel_valid_n = 1'b1;
                        busy_n      = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_n     = IDLE;
                    cnt_n       = '0;
                    sel_valid_n = 1'b0;
                    busy_n      = 1'b0;
                end else if (en) begin
                    if (cnt == LAST) begin
                        cnt_n = '0;
                        if (has_next) begin
                            sel_n = next_sel;
                        end else if (cont_q) begin
                            // Wrap without a gap; done marks the first dwell cycle of the new sweep
                            sel_n  = lowest_bit(mask_q);
                            done_n = 1'b1;
                        end else begin
                            state_n     = IDLE;
                            sel_valid_n = 1'b0;
                            busy_n      = 1'b0;
                            done_n      = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/demux_channel_sequencer.md
# demux_channel_sequencer

Programmable 8-channel scan sequencer that drives the 3-bit select of the 3-to-8 demultiplexer. On a start command it walks the latched set of enabled channels in ascending order, holding each select value for a fixed dwell period, and signals sweep completion. It sits directly upstream of the demux: `sel` connects to the demux `inp`, and `sel_valid` qualifies the demux output for downstream consumers.

## Interface
- `DWELL`, default 4: cycles each enabled channel is held; legal range 1–256.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  begin a sweep; sampled only in IDLE.
- `stop`  input  1  abort the current sweep.
- `en`  input  1  dwell-count enable; low freezes the sequencer in place.
- `cont`  input  1  continuous mode; sampled together with `start`.
- `mask`  input  8  channel enables, bit i = channel i; sampled together with `start`.
- `sel`  output  3  channel index to the demux `inp`.
- `sel_valid`  output  1  `sel` currently addresses an enabled channel in dwell.
- `busy`  output  1  sweep in progress.
- `done`  output  1  one-cycle pulse at sweep completion.

## Operation
- States: IDLE and SCAN.
- Reset: state IDLE, `sel`=0, `sel_valid`=0, `busy`=0, `done`=0, dwell counter 0, latched mask 0, latched cont 0.
- Priority, highest first: `rst`, then `stop`, then `start`, then `en`.
- IDLE with `start`=1:
  - Latch `mask` and `cont`.
  - If the latched mask is nonzero, go to SCAN with `sel` = lowest set bit, `sel_valid`=1, `busy`=1, counter 0.
  - If `mask`=0, stay IDLE and pulse `done` on the next cycle. `sel_valid` never asserts.
- SCAN, each cycle with `en`=1: counter increments. When counter = DWELL-1, the counter clears and `sel` advances to the next higher set bit of the latched mask.
- SCAN with `en`=0: counter, `sel`, and all outputs hold.
- End of sweep, i.e. the dwell of the highest set bit expires:
  - If latched cont=0: go to IDLE with `sel_valid`=0, `busy`=0, `done`=1 for one cycle. `sel` keeps its last value.
  - If latched cont=1: `sel` wraps to the lowest set bit with no gap, `sel_valid` stays 1, and `done` pulses for one cycle, coincident with the first dwell cycle of the new sweep.
- Masked channels are skipped with zero cycles spent on them. A single-bit mask revisits the same channel.
- `stop` in SCAN: go to IDLE next cycle with `sel_valid`=0, `busy`=0, and no `done`. `stop` in IDLE has no effect.
- `start` while in SCAN is ignored. Changes to `mask` or `cont` during SCAN are ignored until the next accepted start.
- Counter width is `$clog2(DWELL)`, minimum 1 bit. For DWELL=1, `sel` advances on every `en` cycle.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- `start` sampled at edge N: `sel`/`sel_valid` are valid from cycle N+1. Latency is 1 cycle.
- Each enabled channel is presented for exactly DWELL cycles with `en` high. Frozen cycles extend the hold.
- Non-continuous sweep over k enabled channels:
  - `busy` is high for k·DWELL cycles, plus any frozen cycles.
  - `done` is asserted in the cycle after the last dwell cycle.
- A new `start` is accepted in the same cycle `done` is high, since the sequencer is already in IDLE. Back-to-back sweeps therefore have a 1-cycle gap.
- `done` and `stop` never coincide for the same sweep. If `stop` is sampled on the final dwell cycle, `stop` wins and there is no `done`.
- `rst` mid-sweep: all outputs take reset values at the next edge.

## Test plan
- `mask`=8'b1010_0101, DWELL=4, `cont`=0, `en`=1, `start` pulse:
  - `sel` sequence is 0,2,5,7, each held 4 cycles, and `sel_valid` is high for 16 cycles.
  - `done`=1 on cycle 17; `busy` is low from cycle 17.
  - Demux output follows 00000001, 00000100, 00100000, 10000000.
- `mask`=8'h00 with `start`: `done` pulses on the next cycle, `sel_valid` and `busy` stay 0.
- `mask`=8'hFF, DWELL=1, `cont`=1:
  - `sel` counts 0..7 and wraps to 0 continuously.
  - `done` pulses on every cycle where `sel`=0 after wrap.
  - `stop` gives IDLE next cycle with no `done`.
- `mask`=8'h10, DWELL=3, `en` low for 2 cycles mid-dwell: `sel`=4 is held 5 cycles total, and `done` is delayed by 2 cycles.
- Changing `mask` to 8'hFF and pulsing `start` during a sweep with `mask`=8'h03:
  - The sweep still visits only channels 0 and 1.
  - Asserting `rst` during channel 1 gives all outputs 0 next edge.
- `stop` asserted on the final dwell cycle of channel 7 (`cont`=0): IDLE next cycle with `done`=0.
